wave_sequencer: RTL and testbench
=================================

# wave_sequencer

Phase-accumulator playback controller for the 256-entry waveform ROM. It generates the ROM address from a fractional phase accumulator and captures the ROM output into a registered sample port with a valid/ready handshake. It can play a fixed number of waveform periods (burst) or play continuously until stopped. It sits between the control logic that supplies `start`, `stop` and tuning, and any downstream sample consumer (DAC interface, PWM, etc.).

## Interface
- `ACC_W`, 16, phase accumulator width; ROM address = `phase[ACC_W-1 -: 8]` (ACC_W ≥ 8)
- `CNT_W`, 8, burst period counter width
- `clk` input 1: single clock, rising edge
- `n_reset` input 1: asynchronous, active-low reset
- `start` input 1: begin playback (sampled in IDLE only)
- `stop` input 1: end playback early (sampled in RUN only)
- `fcw` input ACC_W: frequency control word, latched at start
- `burst_len` input CNT_W: periods to play, latched at start; 0 = continuous
- `rom_addr` output 8: ROM address, combinational from phase register
- `rom_data` input 8: ROM read data (combinational ROM, same-cycle)
- `sample` output 8: captured ROM data
- `sample_valid` output 1: `sample` holds an unaccepted value
- `sample_ready` input 1: consumer accepts when valid && ready
- `sample_last` output 1: qualifies `sample`, marks the last sample of a waveform period
- `busy` output 1: state ≠ IDLE
- `done` output 1: one-cycle pulse at end of playback

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE, `start`=1: latch `fcw_q`←`fcw`, `left`←`burst_len`, `cont`←(`burst_len`==0), `phase`←0, go to RUN. `stop` is ignored in IDLE.
- RUN, capture step: a step occurs when `sample_valid`=0 or (`sample_valid` && `sample_ready`). On a step:
  - `sample`←`rom_data`
  - `sample_valid`←1
  - `{carry, phase}`←`phase`+`fcw_q` (ACC_W-bit wrap)
  - `sample_last`←`carry`
- If `carry` && !`cont`: `left`←`left`−1; if `left` was 1, go to DRAIN on the same edge.
- RUN, no step (stalled): phase, sample and flags are held. No address is skipped or repeated.
- RUN, `stop`=1: no capture that cycle (stop beats a step), go to DRAIN. The pending sample, if any, stays valid.
- DRAIN: no captures. When `sample_valid`=0, or valid && ready:
  - `sample_valid`←0, `sample_last`←0
  - `done`←1 for one cycle
  - go to IDLE
- `start` while busy is ignored. `fcw`/`burst_len` changes while busy have no effect.
- `fcw`=0: address stays at 0 and no carry ever occurs, so a burst never ends; only `stop` terminates.
- Continuous mode: `left` is unused, and `sample_last` still flags period ends.
- Reset (asynchronous, any time, including mid-burst): state IDLE; `phase`, `fcw_q`, `left` = 0; `sample`=0x00; `sample_valid`, `sample_last`, `busy`, `done` = 0; `rom_addr`=0x00.

## Timing
- `start` high in cycle 0 → RUN in cycle 1 with `rom_addr`=0x00 → first `sample_valid` in cycle 2. Start-to-first-sample latency is 2 cycles.
- With `sample_ready` held high, there is one sample per cycle. Throughput is 1/cycle, with no bubbles across period wraps.
- `rom_addr` changes only on a capture step edge (or on start/reset).
- `done` is asserted the cycle after the final handshake, in the same cycle that `sample_valid` falls and `busy` falls.
- `busy` is high from cycle 1 through the cycle before `done`.

## Test plan
- **Reset:** assert `n_reset`=0 asynchronously mid-RUN → all outputs zero immediately. Release reset → IDLE, `busy`=0.
- **Burst:** ROM[i]=i, `fcw`=0x4000, `burst_len`=1, ready=1, start at cycle 0 → samples 0x00,0x40,0x80,0xC0 in cycles 2–5; `sample_last` only with 0xC0; `done` in cycle 6; 4 samples total.
- **Backpressure:** same setup, ready=0 during cycles 3–5 → 0x40 is held valid through cycle 5, then the sequence resumes 0x80,0xC0 with no address skipped; `done` is delayed by 3 cycles.
- **Continuous + stop:** `fcw`=0x0100, `burst_len`=0 → addresses 0x00..0xFF then 0x00 again; `sample_last` with 0xFF. Assert `stop` → no further captures, the pending sample is accepted, then `done`=1.
- **Fractional fcw:** `fcw`=0x0180 → addresses 0x00,0x01,0x03,0x04,0x06,0x07.
- **Start while busy:** `start` pulsed during RUN with a different `fcw` → ignored, and the sequence is unchanged. `start` asserted in the same cycle as `done` → ignored; a start one cycle later is accepted.

Source files
------------

// File: rtl/wave_sequencer.sv
// wave_sequencer: phase-accumulator playback of a 256-entry ROM
// with burst/continuous modes and a valid/ready sample port.
module wave_sequencer #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             stop,
  input  logic [ACC_W-1:0] fcw,
  input  logic [CNT_W-1:0] burst_len,
  output logic [7:0]       rom_addr,
  input  logic [7:0]       rom_data,
  output logic [7:0]       sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             sample_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] fcw_q;
  logic [CNT_W-1:0] left;
  logic             cont;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             go;
  logic             step;
  logic             dec;
  logic             fin;

  assign sum      = {1'b0, phase} + {1'b0, fcw_q};
  assign carry    = sum[ACC_W];
  assign rom_addr = phase[ACC_W-1 -: 8];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A start landing on the done pulse is dropped.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    step      = 1'b0;
    dec       = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !done) begin
          go        = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = DRAIN;
        end else if (!sample_valid || sample_ready) begin
          step = 1'b1;
          if (carry && !cont) begin
            dec = 1'b1;
            if (left == CNT_W'(1)) begin
              state_nxt = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (!sample_valid || sample_ready) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase        <= '0;
      fcw_q        <= '0;
      left         <= '0;
      cont         <= 1'b0;
      sample       <= 8'h00;
      sample_valid <= 1'b0;
      sample_last  <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= fin;
      unique case (1'b1)
        go: begin
          fcw_q <= fcw;
          left  <= burst_len;
          cont  <= (burst_len == '0);
          phase <= '0;
        end
        step: begin
          sample       <= rom_data;
          sample_valid <= 1'b1;
          phase        <= sum[ACC_W-1:0];
          sample_last  <= carry;
          if (dec) begin
            left <= left - 1'b1;
          end
        end
        fin: begin
          sample_valid <= 1'b0;
          sample_last  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: cycle tables for the timing corners plus
// randomized playback against an arithmetic phase model.
module tb_wave_sequencer;

  logic        clk;
  logic        n_reset;
  logic        start;
  logic        stop;
  logic [15:0] fcw;
  logic [7:0]  burst_len;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_last;
  logic        busy;
  logic        done;

  logic [7:0]  rom [256];
  int          n_chk;
  int          n_fail;

  assign rom_data = rom[rom_addr];

  wave_sequencer #(
    .ACC_W(16),
    .CNT_W(8)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .start        (start),
    .stop         (stop),
    .fcw          (fcw),
    .burst_len    (burst_len),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_last  (sample_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rdy;
    logic [15:0] f;
    logic [7:0]  n;
    logic        ev;
    logic [7:0]  es;
    logic        el;
    logic        eb;
    logic        ed;
    logic [7:0]  ea;
  } vec_t;

  vec_t burst_v [10];
  vec_t bp_v [11];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic st, input logic rdy, input logic [15:0] f,
    input logic [7:0] n, input logic ev, input logic [7:0] es,
    input logic el, input logic eb, input logic ed,
    input logic [7:0] ea);
    vec_t v;
    v.st = st; v.rdy = rdy; v.f = f; v.n = n;
    v.ev = ev; v.es = es; v.el = el; v.eb = eb;
    v.ed = ed; v.ea = ea;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag, input int i);
    @(posedge clk);
    #1;
    start        = v.st;
    stop         = 1'b0;
    sample_ready = v.rdy;
    fcw          = v.f;
    burst_len    = v.n;
    @(negedge clk);
    chk($sformatf("%s[%0d].valid", tag, i), 16'(sample_valid), 16'(v.ev));
    chk($sformatf("%s[%0d].sample", tag, i), 16'(sample), 16'(v.es));
    chk($sformatf("%s[%0d].last", tag, i), 16'(sample_last), 16'(v.el));
    chk($sformatf("%s[%0d].busy", tag, i), 16'(busy), 16'(v.eb));
    chk($sformatf("%s[%0d].done", tag, i), 16'(done), 16'(v.ed));
    chk($sformatf("%s[%0d].addr", tag, i), 16'(rom_addr), 16'(v.ea));
  endtask

  // Sample k reads phase k*F; a period ends when (k+1)*F crosses 2^16.
  function automatic logic [7:0] m_addr(input int k, input int f);
    longint p;
    p = (longint'(k) * longint'(f)) % 65536;
    return 8'(p >> 8);
  endfunction

  function automatic logic m_last(input int k, input int f);
    longint a;
    longint b;
    a = (longint'(k) * longint'(f)) / 65536;
    b = ((longint'(k) + 1) * longint'(f)) / 65536;
    return (a != b);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, ".sample"}, 16'(sample), 16'h0);
    chk({tag, ".valid"}, 16'(sample_valid), 16'h0);
    chk({tag, ".last"}, 16'(sample_last), 16'h0);
    chk({tag, ".busy"}, 16'(busy), 16'h0);
    chk({tag, ".done"}, 16'(done), 16'h0);
    chk({tag, ".addr"}, 16'(rom_addr), 16'h0);
  endtask

  task automatic play(input logic [15:0] f, input logic [7:0] n,
                      input int nstop, input int rdy_pct);
    int  k;
    int  expn;
    int  fi;
    bit  hs;
    bit  prev_hs;
    bit  fin;
    bit  stopped;
    k = 0; prev_hs = 0; fin = 0; stopped = 0;
    fi = int'(f);
    if (nstop > 0) expn = nstop + 1;
    else expn = (int'(n) * 65536 + fi - 1) / fi;
    @(posedge clk);
    #1;
    start = 1'b1; fcw = f; burst_len = n;
    stop = 1'b0; sample_ready = 1'b1;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      hs = sample_valid && sample_ready;
      if (hs) begin
        chk($sformatf("play f=%h k=%0d sample", f, k),
            16'(sample), 16'(rom[m_addr(k, fi)]));
        chk($sformatf("play f=%h k=%0d last", f, k),
            16'(sample_last), 16'(m_last(k, fi)));
        k++;
      end
      if (done) begin
        chk($sformatf("play f=%h done.after_hs", f), 16'(prev_hs), 16'h1);
        chk($sformatf("play f=%h count", f), 16'(k), 16'(expn));
        chk($sformatf("play f=%h done.busy", f), 16'(busy), 16'h0);
        chk($sformatf("play f=%h done.valid", f), 16'(sample_valid), 16'h0);
        fin = 1;
      end else if (cyc > 0) begin
        chk($sformatf("play f=%h busy", f), 16'(busy), 16'h1);
      end
      prev_hs = hs;
      @(posedge clk);
      #1;
      start     = fin ? 1'b0 : ($urandom_range(9) == 0);
      fcw       = 16'($urandom);
      burst_len = 8'($urandom);
      stop      = 1'b0;
      if (nstop > 0 && k == nstop && !stopped) begin
        stop = 1'b1; sample_ready = 1'b0; stopped = 1;
      end else begin
        sample_ready = ($urandom_range(99) < rdy_pct);
      end
    end
    start = 1'b0;
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL play f=%h timeout: got %0d samples expected %0d",
               f, k, expn);
      n_reset = 1'b0;
      @(negedge clk);
      n_reset = 1'b1;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    n_reset = 1'b0; start = 1'b0; stop = 1'b0;
    fcw = '0; burst_len = '0; sample_ready = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);

    burst_v[0] = mk(1'b1, 1'b1, 16'h4000, 8'd1,
                    1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    burst_v[1] = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                    1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    burst_v[2] = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                    1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40);
    burst_v[3] = mk(1'b1, 1'b1, 16'h1234, 8'd5,
                    1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'h80);
    burst_v[4] = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                    1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 8'hC0);
    burst_v[5] = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                    1'b1, 8'hC0, 1'b1, 1'b1, 1'b0, 8'h00);
    burst_v[6] = mk(1'b1, 1'b1, 16'h4000, 8'd1,
                    1'b0, 8'hC0, 1'b0, 1'b0, 1'b1, 8'h00);
    burst_v[7] = mk(1'b1, 1'b1, 16'h4000, 8'd1,
                    1'b0, 8'hC0, 1'b0, 1'b0, 1'b0, 8'h00);
    burst_v[8] = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                    1'b0, 8'hC0, 1'b0, 1'b1, 1'b0, 8'h00);
    burst_v[9] = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                    1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40);

    bp_v[0]  = mk(1'b1, 1'b1, 16'h4000, 8'd1,
                  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    bp_v[1]  = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    bp_v[2]  = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                  1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40);
    bp_v[3]  = mk(1'b0, 1'b0, 16'h4000, 8'd1,
                  1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'h80);
    bp_v[4]  = mk(1'b0, 1'b0, 16'h4000, 8'd1,
                  1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'h80);
    bp_v[5]  = mk(1'b0, 1'b0, 16'h4000, 8'd1,
                  1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'h80);
    bp_v[6]  = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                  1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'h80);
    bp_v[7]  = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                  1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 8'hC0);
    bp_v[8]  = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                  1'b1, 8'hC0, 1'b1, 1'b1, 1'b0, 8'h00);
    bp_v[9]  = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                  1'b0, 8'hC0, 1'b0, 1'b0, 1'b1, 8'h00);
    bp_v[10] = mk(1'b0, 1'b1, 16'h4000, 8'd1,
                  1'b0, 8'hC0, 1'b0, 1'b0, 1'b0, 8'h00);

    #12;
    check_zero("por");
    @(negedge clk);
    n_reset = 1'b1;

    for (int i = 0; i < 10; i++) apply(burst_v[i], "burst", i);

    #2;
    n_reset = 1'b0;
    #1;
    check_zero("rst_mid_run");
    @(negedge clk);
    n_reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release.busy", 16'(busy), 16'h0);
    chk("rst_release.valid", 16'(sample_valid), 16'h0);

    for (int i = 0; i < 11; i++) apply(bp_v[i], "backpressure", i);

    play(16'h0100, 8'd0, 300, 100);
    play(16'h0180, 8'd0, 6, 100);
    play(16'h0000, 8'd1, 20, 100);
    play(16'h4000, 8'd2, 0, 50);

    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int r = 0; r < 10; r++) begin
      play(16'($urandom_range(16'hFFFF, 16'h0400)),
           8'($urandom_range(3, 1)), 0, 60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
